// File: rtl/router_input_ctrl.sv
// Ingress controller of the packet switch: parses header/payload/parity bytes,
// steers them into one of NUM_PORTS output FIFOs and keeps packet statistics.
module router_input_ctrl #(
   parameter int NUM_PORTS = 3,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_busy,
   input  logic [NUM_PORTS-1:0] fifo_full,
   output logic [NUM_PORTS-1:0] fifo_wr,
   output logic [7:0]           fifo_data,
   output logic                 pkt_done,
   output logic                 parity_err,
   output logic [CNT_W-1:0]     pkt_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [CNT_W-1:0]     drop_cnt
);

   typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, DROP} state_t;

   localparam logic [2:0] NP = 3'(NUM_PORTS);

   state_t     state;
   logic [1:0] sel;
   logic [7:0] par;
   logic [5:0] remaining;

   logic [1:0] hdr_addr;
   logic [5:0] hdr_len;
   logic       hdr_legal;
   logic [3:0] full_pad;
   logic       accept;
   logic       fwd_byte;
   logic [1:0] wr_port;

   assign hdr_addr  = in_data[1:0];
   assign hdr_len   = in_data[7:2];
   assign hdr_legal = ({1'b0, hdr_addr} < NP);
   // Padding lets an illegal header address index the full flags safely.
   assign full_pad  = 4'(fifo_full);
   assign fifo_data = in_data;
   assign accept    = in_valid && !in_busy;

   always_comb begin
      in_busy = 1'b0;
      case (state)
         IDLE:            in_busy = in_valid && hdr_legal && full_pad[hdr_addr];
         PAYLOAD, PARITY: in_busy = full_pad[sel];
         default:         in_busy = 1'b0;
      endcase
   end

   always_comb begin
      fwd_byte = 1'b0;
      wr_port  = sel;
      case (state)
         IDLE: begin
            fwd_byte = hdr_legal;
            wr_port  = hdr_addr;
         end
         PAYLOAD, PARITY: fwd_byte = 1'b1;
         default:         fwd_byte = 1'b0;
      endcase
      for (int i = 0; i < NUM_PORTS; i++)
         fifo_wr[i] = accept && fwd_byte && (wr_port == 2'(i));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         sel        <= '0;
         par        <= '0;
         remaining  <= '0;
         pkt_done   <= 1'b0;
         parity_err <= 1'b0;
         pkt_cnt    <= '0;
         err_cnt    <= '0;
         drop_cnt   <= '0;
      end else begin
         pkt_done   <= 1'b0;
         parity_err <= 1'b0;
         if (accept) begin
            case (state)
               IDLE: begin
                  remaining <= hdr_len;
                  if (hdr_legal) begin
                     sel   <= hdr_addr;
                     par   <= in_data;
                     state <= (hdr_len != 6'd0) ? PAYLOAD : PARITY;
                  end else begin
                     state <= DROP;
                  end
               end
               PAYLOAD: begin
                  par       <= par ^ in_data;
                  remaining <= remaining - 6'd1;
                  if (remaining == 6'd1)
                     state <= PARITY;
               end
               PARITY: begin
                  pkt_done   <= 1'b1;
                  parity_err <= (in_data != par);
                  if (in_data != par)
                     err_cnt <= err_cnt + CNT_W'(1);
                  else
                     pkt_cnt <= pkt_cnt + CNT_W'(1);
                  state <= IDLE;
               end
               DROP: begin
                  // remaining==0 means the byte in hand is the parity byte.
                  if (remaining == 6'd0) begin
                     drop_cnt <= drop_cnt + CNT_W'(1);
                     state    <= IDLE;
                  end else begin
                     remaining <= remaining - 6'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_router_input_ctrl.sv
// Bench for router_input_ctrl: packet-level reference model, 16-deep FIFO
// occupancy model driving fifo_full, and directed packet scenarios.
module tb_router_input_ctrl;

   localparam int NP = 3;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_busy;
   logic [NP-1:0] fifo_full;
   logic [NP-1:0] fifo_wr;
   logic [7:0]    fifo_data;
   logic          pkt_done;
   logic          parity_err;
   logic [CW-1:0] pkt_cnt;
   logic [CW-1:0] err_cnt;
   logic [CW-1:0] drop_cnt;

   router_input_ctrl #(.NUM_PORTS(NP), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_busy(in_busy), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
      .fifo_data(fifo_data), .pkt_done(pkt_done), .parity_err(parity_err),
      .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // FIFO occupancy model shared with the DUT's reset
   int            fcnt[NP] = '{default: 0};
   int            wr_seen[NP] = '{default: 0};
   logic          auto_drain = 1'b1;
   logic [NP-1:0] pop = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NP; i++) fcnt[i] <= 0;
      end else begin
         for (int i = 0; i < NP; i++)
            fcnt[i] <= fcnt[i] + (fifo_wr[i] ? 1 : 0)
                       - (((auto_drain || pop[i]) && fcnt[i] > 0) ? 1 : 0);
      end
   end

   always @(posedge clk)
      for (int i = 0; i < NP; i++)
         if (fifo_wr[i]) wr_seen[i] <= wr_seen[i] + 1;

   always_comb
      for (int i = 0; i < NP; i++) fifo_full[i] = (fcnt[i] >= 16);

   // Packet-level description of the byte currently on in_data
   logic       cur_fwd = 1'b0;
   logic [1:0] cur_port = 2'd0;
   logic       cur_last = 1'b0;
   logic       cur_bad = 1'b0;
   logic [7:0] pkt[$];

   function automatic logic exp_busy();
      logic [3:0] f4;
      f4 = 4'(fifo_full);
      return in_valid && cur_fwd && f4[cur_port];
   endfunction

   logic          m_done = 1'b0;
   logic          m_perr = 1'b0;
   logic [CW-1:0] m_pkt = '0;
   logic [CW-1:0] m_err = '0;
   logic [CW-1:0] m_drop = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_done <= 1'b0; m_perr <= 1'b0;
         m_pkt <= '0; m_err <= '0; m_drop <= '0;
      end else begin
         m_done <= 1'b0;
         m_perr <= 1'b0;
         if (in_valid && !exp_busy() && cur_last) begin
            if (cur_fwd) begin
               m_done <= 1'b1;
               m_perr <= cur_bad;
               if (cur_bad) m_err <= m_err + 1'b1;
               else         m_pkt <= m_pkt + 1'b1;
            end else begin
               m_drop <= m_drop + 1'b1;
            end
         end
      end
   end

   int done_seen = 0;
   int perr_seen = 0;

   always @(negedge clk) begin
      logic       eb;
      logic [3:0] ew;
      if (chk_en) begin
         eb = exp_busy();
         ew = 4'b0;
         if (in_valid && cur_fwd && !eb) ew[cur_port] = 1'b1;
         check("in_busy", 32'(in_busy), 32'(eb));
         check("fifo_wr", 32'(fifo_wr), 32'(ew[NP-1:0]));
         if (|fifo_wr) check("fifo_data", 32'(fifo_data), 32'(in_data));
         check("pkt_done", 32'(pkt_done), 32'(m_done));
         check("parity_err", 32'(parity_err), 32'(m_perr));
         check("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
         check("err_cnt", 32'(err_cnt), 32'(m_err));
         check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
         if (pkt_done) done_seen++;
         if (parity_err) perr_seen++;
      end
   end

   task automatic set_cur(input int idx);
      logic [7:0] p;
      p = 8'h00;
      for (int k = 0; k < pkt.size() - 1; k++) p = p ^ pkt[k];
      cur_port = pkt[0][1:0];
      cur_fwd  = ({1'b0, pkt[0][1:0]} < 3'(NP));
      cur_last = (idx == pkt.size() - 1);
      cur_bad  = (p != pkt[pkt.size() - 1]);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (!in_busy) break;
         n++;
         if (n > 200) begin
            n_chk++;
            n_err++;
            $display("FAIL accept_timeout: byte %0h still stalled after %0d cycles", b, n);
            $display("Result: errors=%0d of %0d checks", n_err, n_chk);
            $fatal(1, "stalled");
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic end_burst();
      in_valid = 1'b0;
      cur_fwd  = 1'b0;
      cur_last = 1'b0;
   endtask

   task automatic send_pkt(input int n);
      for (int i = 0; i < n; i++) begin
         set_cur(i);
         send_byte(pkt[i]);
      end
      end_burst();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int w0, w1, w2, d0, e0;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      chk_en = 1'b1;

      // Good packet to port 1
      w1 = wr_seen[1]; d0 = done_seen; e0 = perr_seen;
      pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      send_pkt(5);
      idle(2);
      check("good_writes", wr_seen[1] - w1, 5);
      check("good_done", done_seen - d0, 1);
      check("good_perr", perr_seen - e0, 0);
      check("good_pkt_cnt", 32'(pkt_cnt), 1);
      check("good_model_pkt", 32'(m_pkt), 1);

      // Same packet with corrupted parity
      w1 = wr_seen[1]; d0 = done_seen; e0 = perr_seen;
      pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
      send_pkt(5);
      idle(2);
      check("bad_writes", wr_seen[1] - w1, 5);
      check("bad_perr", perr_seen - e0, 1);
      check("bad_err_cnt", 32'(err_cnt), 1);
      check("bad_pkt_cnt", 32'(pkt_cnt), 1);

      // Reset mid-payload, then a fresh packet
      pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      send_pkt(3);
      reset = 1'b1;
      @(negedge clk);
      check("rst_busy", 32'(in_busy), 0);
      check("rst_wr", 32'(fifo_wr), 0);
      check("rst_pkt_cnt", 32'(pkt_cnt), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
      check("rst_done", 32'(pkt_done), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      w1 = wr_seen[1];
      send_pkt(5);
      idle(2);
      check("post_rst_writes", wr_seen[1] - w1, 5);
      check("post_rst_pkt_cnt", 32'(pkt_cnt), 1);

      // Illegal address: dropped, then a normal packet
      w0 = wr_seen[0]; w1 = wr_seen[1]; w2 = wr_seen[2]; d0 = done_seen;
      pkt = '{8'h0B, 8'hAA, 8'hBB, 8'h00};
      send_pkt(4);
      idle(2);
      check("drop_writes", (wr_seen[0] - w0) + (wr_seen[1] - w1) + (wr_seen[2] - w2), 0);
      check("drop_done", done_seen - d0, 0);
      check("drop_cnt_lit", 32'(drop_cnt), 1);
      w1 = wr_seen[1];
      pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      send_pkt(5);
      idle(2);
      check("after_drop_writes", wr_seen[1] - w1, 5);
      check("after_drop_pkt_cnt", 32'(pkt_cnt), 2);

      // Back-pressure: 22-byte packet into an undrained port 0 FIFO
      pkt = {};
      pkt.push_back(8'h50);
      for (int k = 0; k < 20; k++) pkt.push_back(8'(k * 13 + 5));
      begin
         logic [7:0] p;
         p = 8'h00;
         foreach (pkt[k]) p = p ^ pkt[k];
         pkt.push_back(p);
      end
      auto_drain = 1'b0;
      w0 = wr_seen[0];
      for (int i = 0; i < 16; i++) begin
         set_cur(i);
         send_byte(pkt[i]);
      end
      set_cur(16);
      in_data  = pkt[16];
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_busy", 32'(in_busy), 1);
         check("bp_no_wr", 32'(fifo_wr), 0);
      end
      check("bp_16_writes", wr_seen[0] - w0, 16);
      @(posedge clk);
      #1;
      pop[0] = 1'b1;
      @(posedge clk);
      #1;
      pop[0] = 1'b0;
      send_byte(pkt[16]);
      set_cur(17);
      in_data = pkt[17];
      @(negedge clk);
      check("bp_busy_again", 32'(in_busy), 1);
      check("bp_17_writes", wr_seen[0] - w0, 17);
      auto_drain = 1'b1;
      for (int i = 17; i < pkt.size(); i++) begin
         set_cur(i);
         send_byte(pkt[i]);
      end
      end_burst();
      idle(3);
      check("bp_total_writes", wr_seen[0] - w0, 22);
      check("bp_pkt_cnt", 32'(pkt_cnt), 3);

      // Back-to-back zero-length packets after a reset
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      w0 = wr_seen[0]; w2 = wr_seen[2]; d0 = done_seen;
      pkt = '{8'h02, 8'h02};
      send_pkt(2);
      pkt = '{8'h00, 8'h00};
      send_pkt(2);
      idle(2);
      check("b2b_port2", wr_seen[2] - w2, 2);
      check("b2b_port0", wr_seen[0] - w0, 2);
      check("b2b_done", done_seen - d0, 2);
      check("b2b_pkt_cnt", 32'(pkt_cnt), 2);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
